button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Cleans the raw push-button inputs of the vending-machine board and drives the
//  3-bit in_port of the buttons PIO, which does its own edge capture and raises the IRQ.
//  Per channel: 2-flop synchroniser, polarity normalisation, and a 4-state debounce FSM.
//  Also emits one-cycle press and release strobes for local (non-CPU) logic.
// PARAMETERS
//  WIDTH            3          number of button channels
//  DEBOUNCE_CYCLES  1000000    stable-input time before a change is accepted (20 ms @ 50 MHz); >= 2
//  CNT_W            20         counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
//  ACTIVE_LOW       1          1: a raw 0 means pressed (board keys); 0: a raw 1 means pressed
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous reset, active low
//  key_raw      in   WIDTH  raw pad inputs, asynchronous to clk
//  key_level    out  WIDTH  debounced state, 1 = pressed; connects to the PIO in_port
//  key_press    out  WIDTH  one-clk strobe on an accepted press
//  key_release  out  WIDTH  one-clk strobe on an accepted release
// BEHAVIOUR
//  Reset values
//   - Sync flops load the released level: all 1s if ACTIVE_LOW, else all 0s.
//   - FSM = RELEASED, cnt = 0.
//   - key_level, key_press and key_release are all 0.
//  Input conditioning
//   - s = sync2 ^ {WIDTH{ACTIVE_LOW[0]}}; s = 1 means the pressed level is seen.
//  Channel FSM (all outputs registered)
//   - RELEASED:  s=1 -> PRESS_WAIT, cnt<=0.
//   - PRESS_WAIT: s=0 -> RELEASED (bounce; cnt<=0).
//                 s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; key_level<=1; key_press<=1 for one clk.
//                 otherwise cnt<=cnt+1.
//   - PRESSED:   s=0 -> RELEASE_WAIT, cnt<=0.
//   - RELEASE_WAIT: s=1 -> PRESSED (bounce; no strobe).
//                   s=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED; key_level<=0; key_release<=1 for one clk.
//                   otherwise cnt<=cnt+1.
//  Output timing and latency
//   - key_level changes on the same edge that raises the matching strobe.
//   - Strobes are high for exactly one cycle.
//   - Latency: a clean change sampled first at edge k appears on key_level at edge k+DEBOUNCE_CYCLES+2.
//  Boundaries
//   - A pulse or glitch shorter than DEBOUNCE_CYCLES produces no output change and no strobe.
//   - The counter never wraps; it is only compared against the terminal value.
//   - Channels are fully independent; simultaneous accepts on several channels strobe in the same cycle.
//   - key_press and key_release are never both high on one channel.
//   - Reset mid-count discards the count. A key held through reset is reported as a fresh press
//     (key_press) once the full latency has elapsed after reset deasserts.
// STRUCTURE
//  - button_debouncer_defs.vh: state encodings (RELEASED=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2,
//    RELEASE_WAIT=2'd3) as localparams/defines, shared with future keypad logic.
//  - Sub-module debounce_channel: one synchroniser + FSM + counter.
//    Instanced WIDTH times by generate; the top level only does wiring.
// TESTING (bench: DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, WIDTH=3)
//  1. Reset held, key_raw=3'b000 -> all outputs 0. After release with key held, key_level[2:0]=3'b111
//     and key_press=3'b111 for one clk, 6 edges after the first post-reset edge.
//  2. key_raw[0] 1->0 held -> key_level[0] rises on edge k+6 with a 1-clk key_press[0].
//     Raw back to 1 -> key_level[0] falls 6 edges later with a 1-clk key_release[0].
//  3. key_raw[1] low for 3 clks, then high -> key_level[1] stays 0 and no strobe.
//     Same test while pressed (high for 3 clks) -> key_level[1] stays 1.
//  4. Bounce train 0,1,0,1,0 (1 clk each), then steady 0 -> exactly one key_press[2],
//     6 edges after the final steady 0 is sampled.
//  5. All three keys pressed on the same edge -> key_press=3'b111 in one cycle.
//     Keys released on different edges -> independent, correctly timed key_release bits.
//  6. Assert reset_n=0 during PRESS_WAIT (cnt=2) -> outputs 0 immediately (async).
//     After release with the key still held, the full 6-edge latency restarts.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer and future keypad logic.
package button_debouncer_pkg;

   // Channel state encodings; the values are fixed so other logic can decode them.
   typedef enum logic [1:0] {
      StReleased    = 2'd0,
      StPressWait   = 2'd1,
      StPressed     = 2'd2,
      StReleaseWait = 2'd3
   } deb_state_e;

   localparam int unsigned DefaultDebounceCycles = 1000000;  // 20 ms at 50 MHz
   localparam int unsigned DefaultCntW           = 20;

   // Raw pad level that means "not pressed" for the given polarity.
   function automatic logic released_level(input int unsigned active_low);
      return (active_low != 0);
   endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: 2-flop synchroniser, polarity normalisation and debounce FSM.
module button_debouncer_channel
   import button_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
   parameter int unsigned CNT_W           = DefaultCntW,
   parameter int unsigned ACTIVE_LOW      = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_raw,
   output logic o_key_level,
   output logic o_key_press,
   output logic o_key_release
);

   localparam logic             ReleasedRaw = released_level(ACTIVE_LOW);
   localparam logic [CNT_W-1:0] CntLast     = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             w_pressed;
   deb_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_release;

   // Synchroniser resets to the released pad level so no spurious press follows reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= ReleasedRaw;
         r_sync2 <= ReleasedRaw;
      end else begin
         r_sync1 <= i_key_raw;
         r_sync2 <= r_sync1;
      end
   end

   // 1 while the synchronised input shows the pressed level.
   assign w_pressed = r_sync2 ^ ReleasedRaw;

   // Debounce FSM with registered level and one-cycle strobes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= StReleased;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            StReleased: begin
               if (w_pressed) begin
                  r_state <= StPressWait;
                  r_cnt   <= '0;
               end
            end
            StPressWait: begin
               if (!w_pressed) begin
                  r_state <= StReleased;
                  r_cnt   <= '0;
               end else if (r_cnt == CntLast) begin
                  r_state <= StPressed;
                  r_cnt   <= '0;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            StPressed: begin
               if (!w_pressed) begin
                  r_state <= StReleaseWait;
                  r_cnt   <= '0;
               end
            end
            StReleaseWait: begin
               if (w_pressed) begin
                  // Bounce while held: stay pressed, no strobe.
                  r_state <= StPressed;
                  r_cnt   <= '0;
               end else if (r_cnt == CntLast) begin
                  r_state   <= StReleased;
                  r_cnt     <= '0;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= StReleased;
               r_cnt   <= '0;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   assign o_key_level   = r_level;
   assign o_key_press   = r_press;
   assign o_key_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// Debounces the board push-buttons; key_level feeds the buttons PIO in_port.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int unsigned WIDTH           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
   parameter int unsigned CNT_W           = DefaultCntW,
   parameter int unsigned ACTIVE_LOW      = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_key_raw,
   output logic [WIDTH-1:0] o_key_level,
   output logic [WIDTH-1:0] o_key_press,
   output logic [WIDTH-1:0] o_key_release
);

   // Channels are fully independent; one instance per button.
   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      button_debouncer_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
         .i_clk         (i_clk),
         .i_rst_n       (i_rst_n),
         .i_key_raw     (i_key_raw[g]),
         .o_key_level   (o_key_level[g]),
         .o_key_press   (o_key_press[g]),
         .o_key_release (o_key_release[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4 (latency 6 edges).
module tb_button_debouncer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] key_raw;
   logic [2:0] key_level;
   logic [2:0] key_press;
   logic [2:0] key_release;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [2:0] raw;
      logic [2:0] lvl;
      logic [2:0] prs;
      logic [2:0] rel;
   } vec_t;

   vec_t vecs[$];

   button_debouncer #(
      .WIDTH           (3),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3),
      .ACTIVE_LOW      (1)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_key_raw     (key_raw),
      .o_key_level   (key_level),
      .o_key_press   (key_press),
      .o_key_release (key_release)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, ending 1 ns after the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name, input logic [2:0] lvl, input logic [2:0] prs,
                            input logic [2:0] rel);
      check3({name, " level"}, key_level, lvl);
      check3({name, " press"}, key_press, prs);
      check3({name, " release"}, key_release, rel);
   endtask

   task automatic add(input logic [2:0] raw, input logic [2:0] lvl, input logic [2:0] prs,
                      input logic [2:0] rel);
      vecs.push_back({raw, lvl, prs, rel});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      int presses;

      // 1. Reset with all keys held, then full-latency fresh press.
      rst_n   = 1'b0;
      key_raw = 3'b000;
      #12;
      check_all("reset", 3'b000, 3'b000, 3'b000);
      step(1);
      rst_n = 1'b1;
      step(6);
      check_all("post-reset edge6", 3'b000, 3'b000, 3'b000);
      step(1);
      check_all("post-reset edge7", 3'b111, 3'b111, 3'b000);
      step(1);
      check_all("post-reset edge8", 3'b111, 3'b000, 3'b000);
      key_raw = 3'b111;
      step(6);
      check_all("release-all k+5", 3'b111, 3'b000, 3'b000);
      step(1);
      check_all("release-all k+6", 3'b000, 3'b000, 3'b111);
      step(1);
      check_all("release-all k+7", 3'b000, 3'b000, 3'b000);

      // 2. Clean press/release on key 0; 3. short glitch on key 1 while released.
      for (int i = 0; i < 6; i++) add(3'b110, 3'b000, 3'b000, 3'b000);
      add(3'b110, 3'b001, 3'b001, 3'b000);
      add(3'b110, 3'b001, 3'b000, 3'b000);
      for (int i = 0; i < 6; i++) add(3'b111, 3'b001, 3'b000, 3'b000);
      add(3'b111, 3'b000, 3'b000, 3'b001);
      add(3'b111, 3'b000, 3'b000, 3'b000);
      for (int i = 0; i < 3; i++) add(3'b101, 3'b000, 3'b000, 3'b000);
      for (int i = 0; i < 8; i++) add(3'b111, 3'b000, 3'b000, 3'b000);
      foreach (vecs[i]) begin
         key_raw = vecs[i].raw;
         step(1);
         check_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel);
      end

      // 3b. Short release glitch on key 1 while pressed.
      key_raw = 3'b101;
      step(7);
      check_all("k1 press", 3'b010, 3'b010, 3'b000);
      key_raw = 3'b111;
      step(3);
      key_raw = 3'b101;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check_all($sformatf("k1 glitch%0d", i), 3'b010, 3'b000, 3'b000);
      end
      key_raw = 3'b111;
      step(6);
      check_all("k1 rel k+5", 3'b010, 3'b000, 3'b000);
      step(1);
      check_all("k1 rel k+6", 3'b000, 3'b000, 3'b010);
      step(1);

      // 4. Bounce train on key 2, then steady press.
      presses = 0;
      for (int i = 0; i < 4; i++) begin
         key_raw = (i % 2 == 0) ? 3'b011 : 3'b111;
         step(1);
         if (key_press[2]) presses++;
         check_all($sformatf("bounce%0d", i), 3'b000, 3'b000, 3'b000);
      end
      key_raw = 3'b011;
      for (int j = 0; j < 10; j++) begin
         step(1);
         if (key_press[2]) presses++;
         check_all($sformatf("bounce steady%0d", j), (j >= 6) ? 3'b100 : 3'b000,
                   (j == 6) ? 3'b100 : 3'b000, 3'b000);
      end
      n_checks++;
      if (presses != 1) begin
         n_fail++;
         $display("FAIL bounce press count: got %0d, expected 1", presses);
      end
      key_raw = 3'b111;
      step(6);
      check_all("k2 rel k+5", 3'b100, 3'b000, 3'b000);
      step(1);
      check_all("k2 rel k+6", 3'b000, 3'b000, 3'b100);
      step(1);

      // 5. Simultaneous press, staggered releases.
      key_raw = 3'b000;
      step(6);
      check_all("all press k+5", 3'b000, 3'b000, 3'b000);
      step(1);
      check_all("all press k+6", 3'b111, 3'b111, 3'b000);
      step(1);
      for (int o = 0; o < 10; o++) begin
         if (o == 0) key_raw = 3'b001;
         if (o == 1) key_raw = 3'b011;
         if (o == 2) key_raw = 3'b111;
         step(1);
         check_all($sformatf("stagger r+%0d", o),
                   {o < 8, o < 7, o < 6}, 3'b000, {o == 8, o == 7, o == 6});
      end

      // 6. Reset during key-0 press count while key 1 is pressed.
      key_raw = 3'b101;
      step(7);
      check_all("k1 held", 3'b010, 3'b010, 3'b000);
      step(1);
      key_raw = 3'b100;
      step(5);
      rst_n = 1'b0;
      #1;
      check_all("async reset", 3'b000, 3'b000, 3'b000);
      step(2);
      check_all("in reset", 3'b000, 3'b000, 3'b000);
      rst_n = 1'b1;
      step(6);
      check_all("re-press edge6", 3'b000, 3'b000, 3'b000);
      step(1);
      check_all("re-press edge7", 3'b011, 3'b011, 3'b000);
      step(1);
      check_all("re-press edge8", 3'b011, 3'b000, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
